tc_axi_rd_slave: RTL

//  AXI4-Full read-only SLAVE, the responder for the tensorcore read master.

---
 rtl/tc_axi_pkg.sv | 31 +++
 rtl/tc_axi_rd_skid_fifo.sv | 45 ++++
 rtl/tc_axi_rd_slave.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tc_axi_pkg.sv
// Shared AXI read-channel encodings and bundles for the
// tensorcore read slave and its R-channel skid FIFO.
package tc_axi_pkg;

    localparam int TC_ADDR_W = 32;
    localparam int TC_DATA_W = 256;
    localparam int TC_ID_W   = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [TC_ID_W-1:0]   id;
        logic [TC_ADDR_W-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } ar_req_t;

    typedef struct packed {
        logic [TC_ID_W-1:0]   id;
        logic [TC_DATA_W-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } r_beat_t;

endpackage

// File: rtl/tc_axi_rd_skid_fifo.sv
// Two-entry R-beat FIFO absorbing memory data while the
// master stalls rready.
module tc_axi_rd_skid_fifo
    import tc_axi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  r_beat_t    din,
    output r_beat_t    dout,
    output logic [1:0] count
);

    r_beat_t slot [2];
    logic    wr_ptr;
    logic    rd_ptr;

    assign dout = slot[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                slot[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= din;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tc_axi_rd_slave.sv
// AXI4 read-only slave: AR burst -> synchronous memory reads
// -> R beats through a fall-through 2-entry skid FIFO.
module tc_axi_rd_slave
    import tc_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = TC_ADDR_W,
    parameter int DATA_WIDTH = TC_DATA_W,
    parameter int ID_WIDTH   = TC_ID_W,
    parameter int MEM_AW     = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  mem_en,
    output logic [MEM_AW-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int         BEAT_LSB  = $clog2(DATA_WIDTH / 8);
    localparam int         WAW       = ADDR_WIDTH - BEAT_LSB;
    localparam logic [2:0] FULL_SIZE = 3'(BEAT_LSB);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state;
    ar_req_t             req;
    logic [ID_WIDTH-1:0] cur_id;
    logic [WAW-1:0]      waddr;
    logic [8:0]          issue_left;
    logic                err;
    logic                in_valid;
    logic                in_last;
    logic                in_err;
    logic                ar_hs;
    logic                r_hs;
    logic                credit;
    logic                issue;
    logic                push;
    logic                pop;
    logic [1:0]          fifo_count;
    r_beat_t             in_beat;
    r_beat_t             head;
    r_beat_t             rbeat;
    logic                unused;

    assign req = '{
        id:    s_axi_arid,
        addr:  s_axi_araddr,
        len:   s_axi_arlen,
        size:  s_axi_arsize,
        burst: s_axi_arburst
    };

    assign ar_hs = s_axi_arvalid & s_axi_arready;

    // in_valid is the read issued last cycle whose data lands now
    assign credit = ({1'b0, fifo_count} + {2'b00, in_valid}) < 3'd2;
    assign issue  = (state == BURST) && (issue_left != 9'd0) && credit;

    assign mem_en   = issue & ~err;
    assign mem_addr = waddr[MEM_AW-1:0];

    always_comb begin
        in_beat      = '0;
        in_beat.id   = cur_id;
        in_beat.data = in_err ? '0 : mem_rdata;
        in_beat.resp = in_err ? RESP_SLVERR : RESP_OKAY;
        in_beat.last = in_last;
        rbeat        = '0;
        if (fifo_count != 2'd0) begin
            rbeat = head;
        end else if (in_valid) begin
            rbeat = in_beat;
        end
    end

    assign s_axi_rvalid = (fifo_count != 2'd0) | in_valid;
    assign s_axi_rid    = rbeat.id;
    assign s_axi_rdata  = rbeat.data;
    assign s_axi_rresp  = rbeat.resp;
    assign s_axi_rlast  = rbeat.last;

    assign r_hs = s_axi_rvalid & s_axi_rready;
    assign pop  = r_hs & (fifo_count != 2'd0);
    // an empty FIFO lets the arriving beat go straight out
    assign push = in_valid & ~((fifo_count == 2'd0) & s_axi_rready);

    tc_axi_rd_skid_fifo u_fifo (
        .clk   (aclk),
        .rst_n (aresetn),
        .push  (push),
        .pop   (pop),
        .din   (in_beat),
        .dout  (head),
        .count (fifo_count)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            s_axi_arready <= 1'b0;
            cur_id        <= '0;
            waddr         <= '0;
            issue_left    <= 9'd0;
            err           <= 1'b0;
            in_valid      <= 1'b0;
            in_last       <= 1'b0;
            in_err        <= 1'b0;
        end else begin
            in_valid <= issue;
            in_last  <= (issue_left == 9'd1);
            in_err   <= err;
            if (issue) begin
                waddr      <= waddr + WAW'(1);
                issue_left <= issue_left - 9'd1;
            end
            unique case (state)
                IDLE: begin
                    if (ar_hs) begin
                        state         <= BURST;
                        s_axi_arready <= 1'b0;
                        cur_id        <= req.id;
                        waddr         <= req.addr[ADDR_WIDTH-1:BEAT_LSB];
                        issue_left    <= {1'b0, req.len} + 9'd1;
                        err           <= (req.burst != BURST_INCR)
                                       | (req.size != FULL_SIZE);
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                BURST: begin
                    if (r_hs && rbeat.last) begin
                        state         <= IDLE;
                        s_axi_arready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign unused = ^{req.addr[BEAT_LSB-1:0], waddr[WAW-1:MEM_AW]};

endmodule
